add_seq_ctrl: RTL and testbench

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

---
 rtl/add_seq_ctrl.sv | 104 ++++++++++
 tb/tb_add_seq_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/add_seq_ctrl.sv
// Nibble-serial adder: captures A, B and C_in on Start, adds one 4-bit slice per
// clock from the least significant nibble upward, then publishes SUM/C_out/Ovf.
module add_seq_ctrl #(
  parameter int N_NIB = 4,
  localparam int W = 4 * N_NIB
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         C_in,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] SUM,
  output logic         C_out,
  output logic         Ovf
);

  localparam int KW = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_NIB - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t         state, next_state;
  logic [KW-1:0]  k;
  logic [W-1:0]   a_reg, b_reg, res, res_next;
  logic           carry;
  logic [3:0]     a_nib, b_nib;
  logic [4:0]     nib_sum;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: if (Start) next_state = ADD;
      ADD: begin
        Busy = 1'b1;
        if (k == K_LAST) next_state = DONE;
      end
      DONE: begin
        Busy       = 1'b1;
        Done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // One nibble slice per cycle; res_next is the working result with slice k filled in.
  always_comb begin
    a_nib    = a_reg[{k, 2'b00} +: 4];
    b_nib    = b_reg[{k, 2'b00} +: 4];
    nib_sum  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    res_next = res;
    res_next[{k, 2'b00} +: 4] = nib_sum[3:0];
  end

  // Outputs only change on the final slice, so partial sums never leak out.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      k     <= '0;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      res   <= '0;
      SUM   <= '0;
      C_out <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            a_reg <= A;
            b_reg <= B;
            carry <= C_in;
            k     <= '0;
            res   <= '0;
          end
        end
        ADD: begin
          res   <= res_next;
          carry <= nib_sum[4];
          if (k == K_LAST) begin
            k     <= '0;
            SUM   <= res_next;
            C_out <= nib_sum[4];
            Ovf   <= (a_reg[W-1] == b_reg[W-1]) && (res_next[W-1] != a_reg[W-1]);
          end else begin
            k <= k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl (N_NIB=4): directed and random operations
// compared against a whole-word arithmetic model of the adder.
module tb_add_seq_ctrl;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [15:0] A, B;
  logic        C_in;
  logic        Busy, Done;
  logic [15:0] SUM;
  logic        C_out, Ovf;

  int check_count = 0;
  int pass_count  = 0;

  logic [17:0] last_result;
  logic [17:0] exp_q[$];
  logic [17:0] exp_val;

  add_seq_ctrl #(.N_NIB(4)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .A(A), .B(B), .C_in(C_in),
    .Busy(Busy), .Done(Done), .SUM(SUM), .C_out(C_out), .Ovf(Ovf)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference: {Ovf, C_out, SUM} from a plain 17-bit addition and the sign rule.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] full;
    logic        ovf;
    full = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    ovf  = (a[15] == b[15]) && (full[15] != a[15]);
    return {ovf, full};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One complete operation with a Start pulse; operands and Start are scrambled while busy.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin, input string tag);
    logic [17:0] exp;
    exp   = model(a, b, cin);
    A     = a;
    B     = b;
    C_in  = cin;
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    checkOutput({tag, " busy_after_accept"}, {30'b0, Busy, Done}, 32'h2);
    for (int i = 1; i <= 4; i++) begin
      A     = 16'($urandom);
      B     = 16'($urandom);
      C_in  = 1'($urandom);
      Start = (i == 2);
      @(posedge Clock); #1;
      if (i < 4)
        checkOutput({tag, " hold_while_busy"}, {12'b0, Busy, Done, last_result}, {12'b0, 2'b10, last_result});
      else
        checkOutput({tag, " result"}, {12'b0, Busy, Done, Ovf, C_out, SUM}, {12'b0, 2'b11, exp});
    end
    Start = 1'b0;
    @(posedge Clock); #1;
    checkOutput({tag, " idle_after_done"}, {30'b0, Busy, Done}, 32'h0);
    last_result = exp;
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    A     = '0;
    B     = '0;
    C_in  = 1'b0;
    last_result = '0;
    #1;
    checkOutput("reset_state", {12'b0, Busy, Done, Ovf, C_out, SUM}, 32'h0);
    @(posedge Clock); #1;
    Reset = 1'b0;

    $display("[TB] directed operations");
    applyStimulus(16'h1234, 16'h1111, 1'b0, "basic");
    applyStimulus(16'hFFFF, 16'h0000, 1'b1, "ripple");
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, "ovf_pos");
    applyStimulus(16'h8000, 16'h8000, 1'b0, "ovf_neg");

    $display("[TB] random operations");
    for (int n = 0; n < 8; n++)
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), "random");

    $display("[TB] persistence");
    for (int t = 0; t < 20; t++) begin
      @(posedge Clock); #1;
      checkOutput("persist", {12'b0, Busy, Done, Ovf, C_out, SUM}, {14'b0, last_result});
    end

    $display("[TB] back-to-back with Start held");
    Start = 1'b1;
    for (int t = 0; t < 24; t++) begin
      A    = 16'($urandom);
      B    = 16'($urandom);
      C_in = 1'($urandom);
      if (t % 6 == 0) exp_q.push_back(model(A, B, C_in));
      @(posedge Clock); #1;
      checkOutput("b2b_flags", {30'b0, Busy, Done}, {30'b0, (t % 6) != 5, (t % 6) == 4});
      if (t % 6 == 4 && exp_q.size() > 0) begin
        exp_val = exp_q.pop_front();
        checkOutput("b2b_result", {14'b0, Ovf, C_out, SUM}, {14'b0, exp_val});
        last_result = exp_val;
      end
    end
    Start = 1'b0;

    $display("[TB] reset mid-operation");
    A     = 16'hABCD;
    B     = 16'h5678;
    C_in  = 1'b1;
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b1;
    #1;
    checkOutput("async_reset", {12'b0, Busy, Done, Ovf, C_out, SUM}, 32'h0);
    #3;
    Reset = 1'b0;
    last_result = '0;
    for (int t = 0; t < 10; t++) begin
      @(posedge Clock); #1;
      checkOutput("no_done_after_reset", {30'b0, Busy, Done}, 32'h0);
    end

    $display("[TB] Start on first edge after reset");
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    applyStimulus(16'h0F0F, 16'hF0F1, 1'b0, "post_reset");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
